// File: rtl/scaler_matrix_ram_h_pkg.sv
// rtl/scaler_matrix_ram_h_pkg.sv - shared FSM encoding and helpers for the horizontal matrix-RAM responder
package scaler_matrix_ram_h_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EDGE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Flat element position of window (col c, row r) for a k x k window.
  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/scaler_matrix_ram_h_if.sv
// rtl/scaler_matrix_ram_h_if.sv - column stream, matrix-RAM read and status bundle
interface scaler_matrix_ram_h_if #(
  parameter int P  = 8,
  parameter int K  = 4,
  parameter int HW = 11
);
  logic [HW-1:0]    core_arg_img_src_h;
  logic             h_start;
  logic             s_axis_col_valid;
  logic             s_axis_col_ready;
  logic [P*K-1:0]   s_axis_col_pixel;
  logic             matrix_ram_read_en;
  logic             matrix_ram_read_rsp_en;
  logic [P*K*K-1:0] matrix_ram_read_rsp_pixel;
  logic             matrix_ram_read_done;
  logic             status_underflow;

  modport master (
    output core_arg_img_src_h, h_start, s_axis_col_valid, s_axis_col_pixel,
           matrix_ram_read_en, matrix_ram_read_done,
    input  s_axis_col_ready, matrix_ram_read_rsp_en, matrix_ram_read_rsp_pixel,
           status_underflow
  );

  modport slave (
    input  core_arg_img_src_h, h_start, s_axis_col_valid, s_axis_col_pixel,
           matrix_ram_read_en, matrix_ram_read_done,
    output s_axis_col_ready, matrix_ram_read_rsp_en, matrix_ram_read_rsp_pixel,
           status_underflow
  );
endinterface

// File: rtl/scaler_matrix_ram_h_col_fifo.sv
// rtl/scaler_matrix_ram_h_col_fifo.sv - synchronous column FIFO with registered head output
module scaler_matrix_ram_h_col_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             core_clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_head;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_head;

  always_ff @(posedge core_clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push && !o_full)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop  && !o_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge core_clk) begin
    if (i_push && !o_full) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  // Head is valid the cycle after the pop that selected it.
  always_ff @(posedge core_clk) begin
    if (rst) r_head <= '0;
    else if (i_pop && !o_empty && !i_flush) r_head <= r_mem[r_rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/scaler_matrix_ram_h.sv
// rtl/scaler_matrix_ram_h.sv - column buffer and KxK sliding window responder; SCALER_MATRIX_RAM_LEFT_PAD_EN enables left-edge replication
module scaler_matrix_ram_h
  import scaler_matrix_ram_h_pkg::*;
#(
  parameter int PIXEL_BITWIDTH = 8,
  parameter int KERNEL_MAX     = 4,
  parameter int IMG_H_MAX      = 1920,
  parameter int IMG_H_BITWIDTH = clog2(IMG_H_MAX),
  parameter int COL_FIFO_DEPTH = 16
) (
  input logic                 core_clk,
  input logic                 rst,
  scaler_matrix_ram_h_if.slave bus
);
  localparam int P  = PIXEL_BITWIDTH;
  localparam int K  = KERNEL_MAX;
  localparam int CW = P * K;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [IMG_H_BITWIDTH-1:0] r_src_h;
  logic [IMG_H_BITWIDTH-1:0] r_push_cnt;
  logic [IMG_H_BITWIDTH-1:0] r_pop_cnt;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [CW-1:0]             w_fifo_head;
  logic                      w_push;
  logic                      w_read;
  logic                      w_pop;
  logic                      w_underflow_hit;
  logic                      r_p1_vld;
  logic                      r_p1_pop;
  logic                      r_rsp_en;
  logic                      r_underflow;
  logic [CW-1:0]             r_win [K];
  logic [CW-1:0]             w_win_nxt [K];
  logic [P*K*K-1:0]          w_win_flat;
  logic [P*K*K-1:0]          r_rsp_pixel;

  assign bus.s_axis_col_ready          = (r_state == ST_RUN) && !w_fifo_full && (r_push_cnt < r_src_h);
  assign bus.matrix_ram_read_rsp_en    = r_rsp_en;
  assign bus.matrix_ram_read_rsp_pixel = r_rsp_pixel;
  assign bus.status_underflow          = r_underflow;

  assign w_push          = bus.s_axis_col_valid && bus.s_axis_col_ready;
  assign w_read          = bus.matrix_ram_read_en && (r_state != ST_IDLE);
  assign w_pop           = w_read && (r_state == ST_RUN) && !w_fifo_empty && (r_pop_cnt < r_src_h);
  assign w_underflow_hit = w_read && (r_state == ST_RUN) && w_fifo_empty && (r_pop_cnt < r_src_h);

  scaler_matrix_ram_h_col_fifo #(.WIDTH(CW), .DEPTH(COL_FIFO_DEPTH)) u_col_fifo (
    .core_clk    (core_clk),
    .rst         (rst),
    .i_flush     (bus.h_start),
    .i_push      (w_push),
    .i_push_data (bus.s_axis_col_pixel),
    .i_pop       (w_pop),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_head      (w_fifo_head)
  );

  always_ff @(posedge core_clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.h_start) begin
      w_state_nxt = (bus.core_arg_img_src_h == '0) ? ST_EDGE : ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.matrix_ram_read_done) w_state_nxt = ST_IDLE;
          else if (w_pop && (r_pop_cnt + 1'b1 == r_src_h)) w_state_nxt = ST_EDGE;
        end
        ST_EDGE: if (bus.matrix_ram_read_done) w_state_nxt = ST_IDLE;
        ST_IDLE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      r_src_h     <= '0;
      r_push_cnt  <= '0;
      r_pop_cnt   <= '0;
      r_underflow <= 1'b0;
    end else if (bus.h_start) begin
      r_src_h     <= bus.core_arg_img_src_h;
      r_push_cnt  <= '0;
      r_pop_cnt   <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push)          r_push_cnt  <= r_push_cnt + 1'b1;
      if (w_pop)           r_pop_cnt   <= r_pop_cnt + 1'b1;
      if (w_underflow_hit) r_underflow <= 1'b1;
    end
  end

`ifdef SCALER_MATRIX_RAM_LEFT_PAD_EN
  logic r_first;
  always_ff @(posedge core_clk) begin
    if (rst || bus.h_start)      r_first <= 1'b1;
    else if (r_p1_vld && r_p1_pop) r_first <= 1'b0;
  end
`endif

  // Without a pop the newest column is re-inserted, replicating the right edge.
  always_comb begin
    for (int c = 0; c < K - 1; c++) w_win_nxt[c] = r_win[c+1];
    w_win_nxt[K-1] = r_p1_pop ? w_fifo_head : r_win[K-1];
`ifdef SCALER_MATRIX_RAM_LEFT_PAD_EN
    if (r_first && r_p1_pop) begin
      for (int c = 0; c < K; c++) w_win_nxt[c] = w_fifo_head;
    end
`endif
    w_win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w_win_flat[win_idx(r, c, K)*P +: P] = w_win_nxt[c][r*P +: P];
      end
    end
  end

  always_ff @(posedge core_clk) begin
    if (rst || bus.h_start) begin
      r_p1_vld <= 1'b0;
      r_p1_pop <= 1'b0;
      r_rsp_en <= 1'b0;
      for (int c = 0; c < K; c++) r_win[c] <= '0;
    end else begin
      r_p1_vld <= w_read;
      r_p1_pop <= w_pop;
      r_rsp_en <= r_p1_vld;
      if (r_p1_vld) begin
        for (int c = 0; c < K; c++) r_win[c] <= w_win_nxt[c];
      end
    end
  end

  always_ff @(posedge core_clk) begin
    if (rst) r_rsp_pixel <= '0;
    else if (r_p1_vld && !bus.h_start) r_rsp_pixel <= w_win_flat;
  end

endmodule

// File: tb/tb_scaler_matrix_ram_h.sv
// tb/tb_scaler_matrix_ram_h.sv - self-checking bench for scaler_matrix_ram_h; honours SCALER_MATRIX_RAM_LEFT_PAD_EN
module tb_scaler_matrix_ram_h;
  logic core_clk = 1'b0;
  logic rst      = 1'b1;
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;

  typedef struct {
    logic [127:0] win;
    int           due;
  } sb_t;
  sb_t sb [$];

  typedef struct {
    int gap;
    int c0;
    int c1;
    int c2;
    int c3;
  } vec_t;
  vec_t tbl [11];

  scaler_matrix_ram_h_if #(.P(8), .K(4), .HW(11)) bus ();

  scaler_matrix_ram_h dut (
    .core_clk (core_clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 core_clk = ~core_clk;
  always @(posedge core_clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Column c carries pixel c*16+row in each row; c < 0 is an all-zero column.
  function automatic logic [31:0] col_px(input int c);
    logic [31:0] v;
    v = '0;
    if (c >= 0) for (int r = 0; r < 4; r++) v[r*8 +: 8] = 8'(c * 16 + r);
    return v;
  endfunction

  function automatic logic [127:0] win(input int a, input int b, input int c, input int d);
    logic [127:0] w;
    logic [31:0]  px;
    int           cs [4];
    cs[0] = a; cs[1] = b; cs[2] = c; cs[3] = d;
    w = '0;
    for (int ci = 0; ci < 4; ci++) begin
      px = col_px(cs[ci]);
      for (int r = 0; r < 4; r++) w[(r*4+ci)*8 +: 8] = px[r*8 +: 8];
    end
    return w;
  endfunction

  always @(negedge core_clk) begin
    if (!rst && bus.matrix_ram_read_rsp_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_en=1 at cycle %0d with no read outstanding, required 0", cyc);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("rsp_window", bus.matrix_ram_read_rsp_pixel, e.win);
        chk("rsp_latency_cycle", 128'(cyc), 128'(e.due));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge core_clk);
    #1;
  endtask

  task automatic start_line(input int src_h);
    bus.core_arg_img_src_h = 11'(src_h);
    bus.h_start = 1'b1;
    step(1);
    bus.h_start = 1'b0;
  endtask

  task automatic end_line();
    bus.matrix_ram_read_done = 1'b1;
    step(1);
    bus.matrix_ram_read_done = 1'b0;
  endtask

  task automatic do_read(input bit expect_rsp, input logic [127:0] w);
    sb_t e;
    bus.matrix_ram_read_en = 1'b1;
    if (expect_rsp) begin
      e.win = w;
      e.due = cyc + 2;
      sb.push_back(e);
    end
    step(1);
    bus.matrix_ram_read_en = 1'b0;
  endtask

  task automatic push_col(input int c);
    bit done;
    done = 1'b0;
    bus.s_axis_col_valid = 1'b1;
    bus.s_axis_col_pixel = col_px(c);
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge core_clk);
      done = bus.s_axis_col_ready;
      step(1);
    end
    bus.s_axis_col_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL push_timeout col %0d: ready got 0 expected 1", c);
    end
  endtask

  task automatic stream(input int ncyc, input int base, output int acc);
    bit rdy;
    acc = 0;
    bus.s_axis_col_valid = 1'b1;
    bus.s_axis_col_pixel = col_px(base);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge core_clk);
      rdy = bus.s_axis_col_ready;
      step(1);
      if (rdy) begin
        acc++;
        bus.s_axis_col_pixel = col_px(base + acc);
      end
    end
    bus.s_axis_col_valid = 1'b0;
  endtask

  initial begin
    int acc;
    bus.core_arg_img_src_h   = '0;
    bus.h_start              = 1'b0;
    bus.s_axis_col_valid     = 1'b0;
    bus.s_axis_col_pixel     = '0;
    bus.matrix_ram_read_en   = 1'b0;
    bus.matrix_ram_read_done = 1'b0;

    // T1 then T2: 8 spaced reads, then 3 back-to-back reads past the right edge.
`ifdef SCALER_MATRIX_RAM_LEFT_PAD_EN
    tbl[0] = '{1, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 1};
    tbl[2] = '{1, 0, 0, 1, 2};
`else
    tbl[0] = '{1, -1, -1, -1, 0};
    tbl[1] = '{1, -1, -1, 0, 1};
    tbl[2] = '{1, -1, 0, 1, 2};
`endif
    tbl[3]  = '{1, 0, 1, 2, 3};
    tbl[4]  = '{1, 1, 2, 3, 4};
    tbl[5]  = '{1, 2, 3, 4, 5};
    tbl[6]  = '{1, 3, 4, 5, 6};
    tbl[7]  = '{1, 4, 5, 6, 7};
    tbl[8]  = '{0, 5, 6, 7, 7};
    tbl[9]  = '{0, 6, 7, 7, 7};
    tbl[10] = '{0, 7, 7, 7, 7};

    step(3);
    rst = 1'b0;
    @(negedge core_clk);
    chk("reset_ready", 128'(bus.s_axis_col_ready), 128'(0));
    chk("reset_rsp_en", 128'(bus.matrix_ram_read_rsp_en), 128'(0));
    chk("reset_rsp_pixel", bus.matrix_ram_read_rsp_pixel, 128'(0));
    chk("reset_underflow", 128'(bus.status_underflow), 128'(0));
    step(1);

    do_read(1'b0, '0);
    step(4);

    start_line(8);
    for (int c = 0; c < 8; c++) push_col(c);
    for (int i = 0; i < 11; i++) begin
      do_read(1'b1, win(tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].c3));
      step(tbl[i].gap);
    end
    step(4);
    @(negedge core_clk);
    chk("t2_underflow", 128'(bus.status_underflow), 128'(0));
    step(1);
    end_line();
    step(3);

    // T3 backpressure plus T6 first window after h_start.
    start_line(32);
    stream(30, 0, acc);
    chk("t3_accepts_until_full", 128'(acc), 128'(16));
    @(negedge core_clk);
    chk("t3_ready_when_full", 128'(bus.s_axis_col_ready), 128'(0));
    step(1);
`ifdef SCALER_MATRIX_RAM_LEFT_PAD_EN
    do_read(1'b1, win(0, 0, 0, 0));
`else
    do_read(1'b1, win(-1, -1, -1, 0));
`endif
    stream(10, 16, acc);
    chk("t3_accepts_after_one_read", 128'(acc), 128'(1));
    end_line();
    step(3);

    // T4 underflow.
    start_line(8);
    push_col(0);
    push_col(1);
`ifdef SCALER_MATRIX_RAM_LEFT_PAD_EN
    do_read(1'b1, win(0, 0, 0, 0)); step(1);
    do_read(1'b1, win(0, 0, 0, 1)); step(1);
    @(negedge core_clk);
    chk("t4_underflow_before", 128'(bus.status_underflow), 128'(0));
    step(1);
    do_read(1'b1, win(0, 0, 1, 1));
`else
    do_read(1'b1, win(-1, -1, -1, 0)); step(1);
    do_read(1'b1, win(-1, -1, 0, 1)); step(1);
    @(negedge core_clk);
    chk("t4_underflow_before", 128'(bus.status_underflow), 128'(0));
    step(1);
    do_read(1'b1, win(-1, 0, 1, 1));
`endif
    step(3);
    @(negedge core_clk);
    chk("t4_underflow_set", 128'(bus.status_underflow), 128'(1));
    step(5);
    @(negedge core_clk);
    chk("t4_underflow_sticky", 128'(bus.status_underflow), 128'(1));
    step(1);

    // T5 restart with buffered columns and a read in flight.
    start_line(8);
    @(negedge core_clk);
    chk("t5_underflow_cleared", 128'(bus.status_underflow), 128'(0));
    step(1);
    for (int c = 0; c < 5; c++) push_col(c);
    do_read(1'b0, '0);
    start_line(8);
    @(negedge core_clk);
    chk("t5_ready_after_restart", 128'(bus.s_axis_col_ready), 128'(1));
    step(1);
    do_read(1'b1, win(-1, -1, -1, -1));
    step(3);
    @(negedge core_clk);
    chk("t5_fifo_empty_underflow", 128'(bus.status_underflow), 128'(1));
    step(1);
    stream(20, 0, acc);
    chk("t5_push_cnt_restarted", 128'(acc), 128'(8));
    end_line();
    step(5);

    chk("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
